i2s_rx_deserializer: RTL and testbench

//  Receive-side stage after the ADAU1761 codec I2S pins. Oversamples bclk, lrclk and

---
 rtl/i2s_rx_deserializer.sv | 193 +++++++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and deserialises
// standard I2S frames into {left,right} sample pairs on a valid/ready stream.
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enabled,
  input  logic                         bclk,
  input  logic                         lrclk,
  input  logic                         sdata_i,
  output logic signed [DATA_WIDTH-1:0] left_data,
  output logic signed [DATA_WIDTH-1:0] right_data,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         overflow,
  output logic                         frame_err
);

  localparam int               CNT_W    = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_MAX) return CNT_MAX;
    return cnt + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   bclk_s;
  logic                   lr_s;
  logic                   sd_s;

  logic                   bclk_prev;
  logic                   vld_p0;
  logic                   lr_p0;
  logic                   sd_p0;

  logic                          lr_prev_p1;
  logic [CNT_W-1:0]              bit_cnt_p1;
  logic signed [DATA_WIDTH-1:0]  shift_p1;
  logic signed [DATA_WIDTH-1:0]  left_hold_p1;

  state_t state;
  state_t state_nxt;
  logic   lr_chg;
  logic   lr_rise;
  logic   lr_fall;
  logic   slot_ok;
  logic   emit;
  logic   err;
  logic   load_left;

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lr_s   = lrclk_sync[SYNC_STAGES-1];
  assign sd_s   = sdata_sync[SYNC_STAGES-1];

  // Input synchronisers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_i};
    end
  end

  // Stage p0: bclk rising-edge strobe with lrclk/sdata captured alongside
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_prev <= 1'b0;
      vld_p0    <= 1'b0;
      lr_p0     <= 1'b0;
      sd_p0     <= 1'b0;
    end else begin
      bclk_prev <= bclk_s;
      vld_p0    <= bclk_s & ~bclk_prev;
      lr_p0     <= lr_s;
      sd_p0     <= sd_s;
    end
  end

  assign lr_chg  = vld_p0 && (lr_p0 != lr_prev_p1);
  assign lr_rise = lr_chg && lr_p0;
  assign lr_fall = lr_chg && !lr_p0;
  assign slot_ok = (bit_cnt_p1 == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    err       = 1'b0;
    load_left = 1'b0;
    if (!enabled) begin
      state_nxt = ST_IDLE;
    end else if (lr_chg) begin
      case (state)
        ST_IDLE: begin
          if (lr_fall) state_nxt = ST_LEFT;
        end
        ST_LEFT: begin
          if (lr_rise) begin
            if (slot_ok) begin
              load_left = 1'b1;
              state_nxt = ST_RIGHT;
            end else begin
              err       = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_RIGHT: begin
          if (lr_fall) begin
            state_nxt = ST_LEFT;
            if (slot_ok) emit = 1'b1;
            else         err  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p1: bit counter and shift register; the lrclk-edge bit is the previous LSB slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev_p1   <= 1'b0;
      bit_cnt_p1   <= '0;
      shift_p1     <= '0;
      left_hold_p1 <= '0;
    end else begin
      if (vld_p0) lr_prev_p1 <= lr_p0;
      if (!enabled) begin
        bit_cnt_p1 <= '0;
      end else if (vld_p0) begin
        if (lr_chg) begin
          bit_cnt_p1 <= '0;
        end else begin
          if (bit_cnt_p1 < CNT_DATA) shift_p1 <= {shift_p1[DATA_WIDTH-2:0], sd_p0};
          bit_cnt_p1 <= sat_inc(bit_cnt_p1);
        end
      end
      if (load_left) left_hold_p1 <= shift_p1;
    end
  end

  // Stage p2: output pair register with valid/ready handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else if (!enabled) begin
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= err;
      if (emit) begin
        if (!sample_valid || sample_ready) begin
          left_data    <= left_hold_p1;
          right_data   <= shift_p1;
          sample_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench for i2s_rx_deserializer: a bit-level I2S frame driver pushes
// expected pairs; a monitor pops and compares whenever a pair is presented.
module tb_i2s_rx_deserializer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enabled;
  logic          bclk;
  logic          lrclk;
  logic          sdata_i;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          overflow;
  logic          frame_err;

  int              checks   = 0;
  int              failures = 0;
  int              err_cnt  = 0;
  logic            err_prev = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_rx_deserializer #(
    .DATA_WIDTH (DW),
    .SLOT_WIDTH (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enabled     (enabled),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata_i     (sdata_i),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One bclk period of 8 clk; optionally pulse ready in the clk where a rise-triggered emit lands
  task automatic drive_bit(input logic lr, input logic d, input bit pulse);
    bclk    = 1'b0;
    lrclk   = lr;
    sdata_i = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(negedge clk);
    if (pulse) sample_ready = 1'b1;
    @(negedge clk);
    if (pulse) sample_ready = 1'b0;
  endtask

  // Slot bit 0 is the lrclk-edge bit; data MSB occupies bit 1
  task automatic send_bits(input logic lr, input logic [DW-1:0] d, input int from, input int to,
                           input bit pulse_first);
    for (int i = from; i < to; i++) begin
      drive_bit(lr, (i >= 1 && i <= DW) ? d[DW-i] : 1'b0, pulse_first && (i == from));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_bits(1'b0, l, 0, 32, 1'b0);
    send_bits(1'b1, r, 0, 32, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && sample_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pair actual=%0h_%0h required=none", left_data, right_data);
        end else begin
          check("pair", {left_data, right_data}, exp_q[0]);
          if (sample_ready) exp_q.delete(0);
        end
      end
      if (frame_err) begin
        err_cnt++;
        check("frame_err_width", 48'(err_prev), 48'd0);
      end
      err_prev = frame_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n      = 1'b0;
    enabled      = 1'b1;
    bclk         = 1'b0;
    lrclk        = 1'b0;
    sdata_i      = 1'b0;
    sample_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", 48'(sample_valid), 48'd0);
    check("rst_overflow", 48'(overflow), 48'd0);
    check("rst_frame_err", 48'(frame_err), 48'd0);
    check("rst_data", {left_data, right_data}, 48'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // first frame after reset is not framed (IDLE waits for an lrclk fall)
    send_frame(24'h000000, 24'h000000);
    exp_q.push_back({24'h123456, 24'hABCDEF});
    send_frame(24'h123456, 24'hABCDEF);

    // pair held with ready low, then reset mid right slot
    exp_q.push_back({24'hFEDCBA, 24'h012345});
    send_bits(1'b0, 24'hFEDCBA, 0, 32, 1'b0);
    sample_ready = 1'b0;
    send_bits(1'b1, 24'h012345, 0, 32, 1'b0);
    send_bits(1'b0, 24'h111111, 0, 32, 1'b0);
    send_bits(1'b1, 24'h222222, 0, 10, 1'b0);
    check("t1_valid_before_reset", 48'(sample_valid), 48'd1);
    check("t2_drained", 48'(exp_q.size()), 48'd1);
    reset_n = 1'b0;
    #1;
    check("t1_rst_valid", 48'(sample_valid), 48'd0);
    check("t1_rst_data", {left_data, right_data}, 48'd0);
    check("t1_rst_overflow", 48'(overflow), 48'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n      = 1'b1;
    sample_ready = 1'b1;
    send_bits(1'b1, 24'h222222, 10, 32, 1'b0);
    exp_q.push_back({24'h0A0A0A, 24'hF50505});
    send_frame(24'h0A0A0A, 24'hF50505);

    // back-pressure across two frames: second pair dropped
    exp_q.push_back({24'h800000, 24'h7FFFFF});
    send_bits(1'b0, 24'h800000, 0, 32, 1'b0);
    sample_ready = 1'b0;
    send_bits(1'b1, 24'h7FFFFF, 0, 32, 1'b0);
    send_frame(24'h000001, 24'hFFFFFF);
    send_bits(1'b0, 24'h333333, 0, 1, 1'b0);
    check("t3_overflow", 48'(overflow), 48'd1);
    check("t3_valid_held", 48'(sample_valid), 48'd1);
    check("t3_data_held", {left_data, right_data}, {24'h800000, 24'h7FFFFF});
    sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_valid_drop", 48'(sample_valid), 48'd0);

    // short right slot
    send_bits(1'b0, 24'h333333, 1, 32, 1'b0);
    send_bits(1'b1, 24'h444444, 0, 20, 1'b0);
    exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
    send_bits(1'b0, 24'h5A5A5A, 0, 32, 1'b0);
    check("t4_frame_errs", 48'(err_cnt), 48'd1);
    send_bits(1'b1, 24'hA5A5A5, 0, 32, 1'b0);

    // disable for 10 bclk mid left slot
    send_bits(1'b0, 24'h666666, 0, 12, 1'b0);
    check("t5_overflow_before", 48'(overflow), 48'd1);
    enabled = 1'b0;
    send_bits(1'b0, 24'h666666, 12, 22, 1'b0);
    check("t5_dis_valid", 48'(sample_valid), 48'd0);
    check("t5_dis_overflow", 48'(overflow), 48'd0);
    check("t5_dis_frame_err", 48'(frame_err), 48'd0);
    enabled = 1'b1;
    send_bits(1'b0, 24'h666666, 22, 32, 1'b0);
    send_bits(1'b1, 24'h777777, 0, 32, 1'b0);
    exp_q.push_back({24'h246802, 24'hFDB975});
    send_frame(24'h246802, 24'hFDB975);

    // ready pulse coincides with a new emit
    sample_ready = 1'b0;
    exp_q.push_back({24'h13579B, 24'hECA864});
    send_frame(24'h13579B, 24'hECA864);
    send_bits(1'b0, 24'h000000, 0, 1, 1'b1);
    check("t6_valid_stays", 48'(sample_valid), 48'd1);
    check("t6_overflow", 48'(overflow), 48'd0);
    check("t6_new_pair", {left_data, right_data}, {24'h13579B, 24'hECA864});
    sample_ready = 1'b1;
    send_bits(1'b0, 24'h000000, 1, 32, 1'b0);
    send_bits(1'b1, 24'h000000, 0, 32, 1'b0);

    check("end_queue_empty", 48'(exp_q.size()), 48'd0);
    check("end_frame_errs", 48'(err_cnt), 48'd1);
    check("end_valid", 48'(sample_valid), 48'd0);
    check("end_overflow", 48'(overflow), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
